adc_spi_sampler: RTL and testbench

SPI master that periodically reads a 16-bit two's-complement ADC and presents each result as a signed sample with a one-cycle valid strobe. It is the producer for the distance lookup stage: its raw_adc_data output drives that stage's raw ADC input directly. One frame per sample period; the channel select is sent on MOSI while the result arrives on MISO.

---
 rtl/adc_spi_sampler.sv | 180 ++++++++++++++++++
 tb/tb_adc_spi_sampler.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/adc_spi_sampler.sv
// Periodic SPI master (mode 0) reading a 16-bit two's-complement ADC; one frame per sample period.
// Build option: define ADC_AVG4_EN to present a 4-deep moving average instead of the raw word.
module adc_spi_sampler #(
  parameter int unsigned CLK_DIV       = 4,
  parameter int unsigned SAMPLE_PERIOD = 5000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic [2:0]  channel,
  output logic        sclk,
  output logic        cs_n,
  output logic        mosi,
  input  logic        miso,
  output logic [15:0] raw_adc_data,
  output logic        data_valid,
  output logic        busy
);

  localparam int unsigned FRAME = (2 + 2 * 16) * CLK_DIV;
  localparam int unsigned TMAX  = (SAMPLE_PERIOD > FRAME + CLK_DIV) ? SAMPLE_PERIOD : FRAME + CLK_DIV;
  localparam int unsigned TW    = $clog2(TMAX + 1);
  localparam int unsigned CW    = $clog2(CLK_DIV);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CS_SETUP,
    S_SHIFT,
    S_CS_HOLD,
    S_GAP
  } state_t;

  state_t        r_state, w_state_nx;
  logic [CW-1:0] r_cnt, w_cnt_nx;
  logic [3:0]    r_bit, w_bit_nx;
  logic [TW-1:0] r_timer, w_timer_nx;
  logic [15:0]   r_cmd, w_cmd_nx;
  logic [15:0]   r_shift, w_shift_nx;
  logic [15:0]   r_raw, w_raw_nx;
  logic          r_sclk, w_sclk_nx;
  logic          r_mosi, w_mosi_nx;
  logic          r_cs_n, r_busy, r_valid;
  logic          w_valid_nx, w_frame_nx, w_start, w_cnt_last;
  logic [15:0]   w_result;

  assign w_cnt_last = (r_cnt == CW'(CLK_DIV - 1));

  always_comb begin
    w_state_nx = r_state;
    w_cnt_nx   = r_cnt + 1'b1;
    w_bit_nx   = r_bit;
    w_timer_nx = (r_timer == TW'(TMAX)) ? r_timer : r_timer + 1'b1;
    w_cmd_nx   = r_cmd;
    w_shift_nx = r_shift;
    w_raw_nx   = r_raw;
    w_sclk_nx  = r_sclk;
    w_mosi_nx  = r_mosi;
    w_valid_nx = 1'b0;
    w_start    = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_cnt_nx = '0;
        w_start  = enable;
      end
      S_CS_SETUP: begin
        if (w_cnt_last) begin
          w_state_nx = S_SHIFT;
          w_cnt_nx   = '0;
          w_bit_nx   = '0;
        end
      end
      S_SHIFT: begin
        if (w_cnt_last) begin
          w_cnt_nx = '0;
          if (!r_sclk) begin
            // miso is captured on the same clk edge that raises sclk
            w_sclk_nx  = 1'b1;
            w_shift_nx = {r_shift[14:0], miso};
          end else begin
            w_sclk_nx = 1'b0;
            if (r_bit == 4'd15) begin
              w_state_nx = S_CS_HOLD;
            end else begin
              w_bit_nx  = r_bit + 1'b1;
              w_mosi_nx = r_cmd[14];
              w_cmd_nx  = {r_cmd[14:0], 1'b0};
            end
          end
        end
      end
      S_CS_HOLD: begin
        if (w_cnt_last) begin
          w_state_nx = S_GAP;
          w_cnt_nx   = '0;
          w_valid_nx = 1'b1;
          w_raw_nx   = w_result;
          w_mosi_nx  = 1'b0;
        end
      end
      S_GAP: begin
        if (w_cnt_last) w_cnt_nx = r_cnt;
        // Leave only once both the period and the minimum cs_n-high time are met
        if (w_cnt_last && r_timer >= TW'(SAMPLE_PERIOD - 1)) begin
          if (enable) w_start = 1'b1;
          else        w_state_nx = S_IDLE;
        end
      end
      default: w_state_nx = S_IDLE;
    endcase
    if (w_start) begin
      w_state_nx = S_CS_SETUP;
      w_cnt_nx   = '0;
      w_timer_nx = '0;
      w_cmd_nx   = {1'b1, channel, 12'h000};
      w_mosi_nx  = 1'b1;
    end
    w_frame_nx = (w_state_nx inside {S_CS_SETUP, S_SHIFT, S_CS_HOLD});
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_bit   <= '0;
      r_timer <= '0;
      r_cmd   <= '0;
      r_shift <= '0;
      r_raw   <= '0;
      r_sclk  <= 1'b0;
      r_mosi  <= 1'b0;
      r_cs_n  <= 1'b1;
      r_busy  <= 1'b0;
      r_valid <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_cnt   <= w_cnt_nx;
      r_bit   <= w_bit_nx;
      r_timer <= w_timer_nx;
      r_cmd   <= w_cmd_nx;
      r_shift <= w_shift_nx;
      r_raw   <= w_raw_nx;
      r_sclk  <= w_sclk_nx;
      r_mosi  <= w_mosi_nx;
      r_cs_n  <= !w_frame_nx;
      r_busy  <= w_frame_nx;
      r_valid <= w_valid_nx;
    end
  end

`ifdef ADC_AVG4_EN
  logic [15:0]        r_hist [3];
  logic signed [17:0] w_sum;

  always_comb begin
    w_sum = 18'(signed'(r_shift)) + 18'(signed'(r_hist[0]))
          + 18'(signed'(r_hist[1])) + 18'(signed'(r_hist[2]));
    w_result = 16'(w_sum >>> 2);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < 3; i++) r_hist[i] <= '0;
    end else if (w_valid_nx) begin
      r_hist[0] <= r_shift;
      r_hist[1] <= r_hist[0];
      r_hist[2] <= r_hist[1];
    end
  end
`else
  assign w_result = r_shift;
`endif

  assign sclk         = r_sclk;
  assign cs_n         = r_cs_n;
  assign mosi         = r_mosi;
  assign raw_adc_data = r_raw;
  assign data_valid   = r_valid;
  assign busy         = r_busy;

endmodule

// File: tb/tb_adc_spi_sampler.sv
// Bench for adc_spi_sampler: frame-timing model with per-cycle compare plus directed literal checks.
module tb_adc_spi_sampler;

  localparam int SP        = 5000;
  localparam int FRAME_LEN = 136;
  localparam int LOOP_LEN  = (SP > FRAME_LEN + 4) ? SP : FRAME_LEN + 4;

  logic        clk, reset, enable, en_fast, miso, miso_f;
  logic [2:0]  channel;
  logic        sclk, cs_n, mosi, data_valid, busy;
  logic [15:0] raw_adc_data;
  logic        sclk_f, cs_n_f, mosi_f, data_valid_f, busy_f;
  logic [15:0] raw_f;
  logic [15:0] adc_word;

  adc_spi_sampler #(.CLK_DIV(4), .SAMPLE_PERIOD(SP)) dut (
    .clk(clk), .reset(reset), .enable(enable), .channel(channel),
    .sclk(sclk), .cs_n(cs_n), .mosi(mosi), .miso(miso),
    .raw_adc_data(raw_adc_data), .data_valid(data_valid), .busy(busy)
  );

  adc_spi_sampler #(.CLK_DIV(4), .SAMPLE_PERIOD(100)) dut_fast (
    .clk(clk), .reset(reset), .enable(en_fast), .channel(channel),
    .sclk(sclk_f), .cs_n(cs_n_f), .mosi(mosi_f), .miso(miso_f),
    .raw_adc_data(raw_f), .data_valid(data_valid_f), .busy(busy_f)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

`ifdef ADC_AVG4_EN
  localparam logic [15:0] EXP_F1 = 16'h068A;
  localparam logic [15:0] EXP_F2 = 16'h0658;
  localparam int          EXP_F2_S = 1624;
  localparam logic [15:0] EXP_F3 = 16'h06A1;
  localparam logic [15:0] EXP_F4 = 16'hE6A1;
`else
  localparam logic [15:0] EXP_F1 = 16'h1A2B;
  localparam logic [15:0] EXP_F2 = 16'hFF38;
  localparam int          EXP_F2_S = -200;
  localparam logic [15:0] EXP_F3 = 16'h0123;
  localparam logic [15:0] EXP_F4 = 16'h8000;
`endif
  logic [15:0] word_tab [4];
  logic [15:0] exp_tab  [4];

  int n_pass = 0;
  int n_total = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
  endtask

  // ADC model: MSB presented on cs_n fall, next bit after each sclk fall
  logic [15:0] adc_frame;
  int          adc_idx;
  always @(negedge cs_n) begin
    adc_frame = adc_word;
    adc_idx   = 15;
    miso      = adc_frame[15];
  end
  always @(negedge sclk) begin
    if (!cs_n && adc_idx > 0) begin
      adc_idx = adc_idx - 1;
      miso    = adc_frame[adc_idx];
    end
  end

  // Behavioural model: frame position is time since the frame start
  int          m_t = 0;
  int          m_fstart = 0;
  bit          m_idle = 1'b1;
  logic [15:0] m_cmd = '0;
  logic [15:0] m_word = '0;
  logic [15:0] m_raw = '0;
  int          hq[$] = '{0, 0, 0};
  logic        e_cs_n = 1'b1, e_sclk = 1'b0, e_mosi = 1'b0, e_busy = 1'b0, e_valid = 1'b0;

  task start_frame();
    m_fstart = m_t;
    m_idle   = 1'b0;
    m_cmd    = {1'b1, channel, 12'h000};
    m_word   = adc_word;
  endtask

  task model_result();
`ifdef ADC_AVG4_EN
    int s;
    hq.push_front(int'($signed(m_word)));
    s = hq[0] + hq[1] + hq[2] + hq[3];
    void'(hq.pop_back());
    m_raw = 16'(s >>> 2);
`else
    m_raw = m_word;
`endif
  endtask

  always @(posedge clk) begin
    int off, b;
    m_t++;
    e_valid = 1'b0;
    if (reset) begin
      m_idle = 1'b1;
      m_raw  = '0;
      hq     = '{0, 0, 0};
    end else begin
      if (m_idle) begin
        if (enable) start_frame();
      end else if (m_t - m_fstart == LOOP_LEN) begin
        if (enable) start_frame();
        else        m_idle = 1'b1;
      end
      if (!m_idle && m_t - m_fstart == FRAME_LEN) begin
        e_valid = 1'b1;
        model_result();
      end
    end
    e_cs_n = 1'b1; e_busy = 1'b0; e_sclk = 1'b0; e_mosi = 1'b0;
    if (!m_idle) begin
      off = m_t - m_fstart;
      if (off < FRAME_LEN) begin
        e_cs_n = 1'b0;
        e_busy = 1'b1;
        e_sclk = (off >= 4) && (off < FRAME_LEN - 4) && (((off - 4) % 8) >= 4);
        b = (off < 4) ? 0 : (off - 4) / 8;
        if (b > 15) b = 15;
        e_mosi = m_cmd[15 - b];
      end
    end
  end

  always @(posedge clk) begin
    #1;
    chk("cs_n", 32'(cs_n), 32'(e_cs_n));
    chk("sclk", 32'(sclk), 32'(e_sclk));
    chk("mosi", 32'(mosi), 32'(e_mosi));
    chk("busy", 32'(busy), 32'(e_busy));
    chk("data_valid", 32'(data_valid), 32'(e_valid));
    chk("raw_adc_data", 32'(raw_adc_data), 32'(m_raw));
  end

  // Observation of DUT activity (actual values only)
  int cyc = 0, fall_cnt = 0, fall_cyc = 0, period = 0, low_len = 0, rises = 0, valid_cnt = 0;
  logic [15:0] mosi_cap = '0;
  logic prev_cs = 1'b1, prev_sclk = 1'b0;
  int f_rise_cyc = 0, f_fall_cyc = 0, f_high = 0, f_period = 0;
  logic prev_csf = 1'b1;

  always @(posedge clk) begin
    #1;
    cyc++;
    if (prev_cs && !cs_n) begin
      fall_cnt++;
      period   = cyc - fall_cyc;
      fall_cyc = cyc;
      rises    = 0;
      mosi_cap = '0;
    end
    if (!prev_cs && cs_n) low_len = cyc - fall_cyc;
    if (sclk && !prev_sclk) begin
      rises++;
      mosi_cap = {mosi_cap[14:0], mosi};
    end
    if (data_valid) valid_cnt++;
    prev_cs   = cs_n;
    prev_sclk = sclk;
    if (!prev_csf && cs_n_f) f_rise_cyc = cyc;
    if (prev_csf && !cs_n_f) begin
      f_high     = cyc - f_rise_cyc;
      f_period   = cyc - f_fall_cyc;
      f_fall_cyc = cyc;
    end
    prev_csf = cs_n_f;
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_fall(input int maxc);
    int start, n;
    start = fall_cnt; n = 0;
    while (fall_cnt == start && n < maxc) begin @(negedge clk); n++; end
    chk("wait_cs_fall", 32'(fall_cnt != start), 32'd1);
  endtask

  task automatic wait_valid(input int maxc);
    int start, n;
    start = valid_cnt; n = 0;
    while (valid_cnt == start && n < maxc) begin @(negedge clk); n++; end
    chk("wait_valid", 32'(valid_cnt != start), 32'd1);
  endtask

  task automatic wait_rises(input int target, input int maxc);
    int n;
    n = 0;
    while (rises < target && n < maxc) begin @(negedge clk); n++; end
    chk("wait_sclk_rises", 32'(rises >= target), 32'd1);
  endtask

  initial begin
    int vsnap, fsnap;
    word_tab = '{16'h0190, 16'h0320, 16'hFE70, 16'h04B0};
`ifdef ADC_AVG4_EN
    exp_tab  = '{16'd100, 16'd300, 16'd200, 16'd500};
`else
    exp_tab  = '{16'h0190, 16'h0320, 16'hFE70, 16'h04B0};
`endif
    reset = 1'b1; enable = 1'b0; en_fast = 1'b0; channel = 3'd5;
    miso = 1'b0; miso_f = 1'b0; adc_word = 16'h1A2B;
    tick(3);
    chk("rst_cs_n", 32'(cs_n), 32'd1);
    chk("rst_raw", 32'(raw_adc_data), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    reset = 1'b0;
    tick(2);

    // Frame 1: channel 5, ADC returns 0x1A2B; channel change mid-frame is ignored
    enable = 1'b1; en_fast = 1'b1;
    wait_fall(10);
    vsnap = valid_cnt;
    tick(20);
    channel = 3'd2;
    wait_valid(200);
    chk("f1_raw", 32'(raw_adc_data), 32'(EXP_F1));
    chk("f1_mosi_word", 32'(mosi_cap), 32'h0000D000);
    chk("f1_sclk_rises", 32'(rises), 32'd16);
    chk("f1_cs_low_len", 32'(low_len), 32'd136);
    tick(5);
    chk("f1_valid_pulses", 32'(valid_cnt - vsnap), 32'd1);

    // Frame 2: negative sample, period check, back-to-back fast instance
    adc_word = 16'hFF38;
    wait_fall(5100);
    chk("period_5000", 32'(period), 32'd5000);
    wait_valid(200);
    chk("f2_raw", 32'(raw_adc_data), 32'(EXP_F2));
    chk("f2_raw_signed", 32'($signed(raw_adc_data)), 32'(EXP_F2_S));
    chk("f2_mosi_word", 32'(mosi_cap), 32'h0000A000);
    chk("fast_cs_high", 32'(f_high), 32'd4);
    chk("fast_period", 32'(f_period), 32'd140);

    // Frame 3: enable dropped mid-frame; frame still completes
    adc_word = 16'h0123;
    wait_fall(5100);
    vsnap = valid_cnt;
    wait_rises(3, 100);
    enable = 1'b0;
    wait_valid(200);
    chk("f3_raw", 32'(raw_adc_data), 32'(EXP_F3));
    tick(5);
    chk("f3_valid_pulses", 32'(valid_cnt - vsnap), 32'd1);
    fsnap = fall_cnt;
    tick(5100);
    chk("idle_no_frame", 32'(fall_cnt - fsnap), 32'd0);
    chk("idle_cs_n", 32'(cs_n), 32'd1);
    adc_word = 16'h8000;
    enable = 1'b1;
    tick(1);
    chk("restart_cs_n", 32'(cs_n), 32'd0);
    wait_valid(200);
    chk("f4_raw", 32'(raw_adc_data), 32'(EXP_F4));

    // Frame 5 abandoned by reset in bit 7
    adc_word = 16'h7777;
    wait_fall(5100);
    wait_rises(8, 150);
    vsnap = valid_cnt;
    reset = 1'b1;
    #1;
    chk("rst_mid_cs_n", 32'(cs_n), 32'd1);
    chk("rst_mid_sclk", 32'(sclk), 32'd0);
    chk("rst_mid_busy", 32'(busy), 32'd0);
    adc_word = word_tab[0];
    tick(3);
    reset = 1'b0;
    #1;
    chk("rst_mid_raw", 32'(raw_adc_data), 32'd0);
    chk("rst_mid_no_valid", 32'(valid_cnt - vsnap), 32'd0);

    // Sample sequence 400, 800, -400, 1200
    for (int i = 0; i < 4; i++) begin
      wait_valid(5200);
      chk($sformatf("seq_raw_%0d", i), 32'(raw_adc_data), 32'(exp_tab[i]));
      if (i < 3) adc_word = word_tab[i + 1];
    end

    enable = 1'b0; en_fast = 1'b0;
    tick(200);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
